// File: rtl/rf_pkg.sv
// Shared constants and types for the mini-CPU register file, decode stage and ALU.
package rf_pkg;

    localparam int RF_DATA_W = 8;
    localparam int RF_DEPTH  = 8;

    function automatic int rf_addr_w(input int depth);
        return $clog2(depth);
    endfunction

    typedef logic [RF_DATA_W-1:0]        rf_data_t;
    typedef logic [$clog2(RF_DEPTH)-1:0] rf_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: one reserve (set) port, NW completion (clear) ports.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int DEPTH    = RF_DEPTH,
    parameter int NW       = 2,
    parameter int ZERO_REG = 0,
    parameter int ADDR_W   = rf_addr_w(DEPTH)
) (
    input  logic                 clk,
    input  logic                 areset_n,
    input  logic [NW-1:0]        clr_en,
    input  logic [NW*ADDR_W-1:0] clr_addr,
    input  logic                 set_en,
    input  logic [ADDR_W-1:0]    set_addr,
    output logic [DEPTH-1:0]     busy_nxt,
    output logic [DEPTH-1:0]     busy_vec
);

    // Set is applied after the clears so a new producer wins over a completing one.
    always_comb begin
        busy_nxt = busy_vec;
        for (int k = 0; k < NW; k++) begin
            if (clr_en[k]) busy_nxt[clr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
        end
        if (set_en) busy_nxt[set_addr] = 1'b1;
        if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) busy_vec <= '0;
        else           busy_vec <= busy_nxt;
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with registered reads, optional bypass,
// optional hardwired zero register and a busy scoreboard.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NR       = 2,
    parameter int NW       = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    parameter int ADDR_W   = rf_addr_w(DEPTH)
) (
    input  logic                 clk,
    input  logic                 areset_n,
    input  logic [NW-1:0]        we,
    input  logic [NW*ADDR_W-1:0] waddr,
    input  logic [NW*DATA_W-1:0] wdata,
    input  logic [NR-1:0]        re,
    input  logic [NR*ADDR_W-1:0] raddr,
    output logic [NR*DATA_W-1:0] rdata,
    output logic [NR-1:0]        rbusy,
    input  logic                 rsv_en,
    input  logic [ADDR_W-1:0]    rsv_addr,
    output logic [DEPTH-1:0]     busy_vec
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy_nxt;
    logic [ADDR_W-1:0] ra     [NR];
    logic [DATA_W-1:0] rd_nxt [NR];
    logic [NR-1:0]     rb_nxt;

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .NW       (NW),
        .ZERO_REG (ZERO_REG),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .areset_n (areset_n),
        .clr_en   (we),
        .clr_addr (waddr),
        .set_en   (rsv_en),
        .set_addr (rsv_addr),
        .busy_nxt (busy_nxt),
        .busy_vec (busy_vec)
    );

    // Later write ports are assigned last, so the higher index wins a collision.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int k = 0; k < NW; k++) begin
                if (we[k] && !(ZERO_REG != 0 && waddr[k*ADDR_W +: ADDR_W] == '0))
                    mem[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rb_nxt = '0;
        for (int j = 0; j < NR; j++) begin
            ra[j]     = raddr[j*ADDR_W +: ADDR_W];
            rd_nxt[j] = mem[ra[j]];
            if (BYPASS != 0) begin
                for (int k = 0; k < NW; k++) begin
                    if (we[k] && waddr[k*ADDR_W +: ADDR_W] == ra[j])
                        rd_nxt[j] = wdata[k*DATA_W +: DATA_W];
                end
                rb_nxt[j] = busy_nxt[ra[j]];
            end else begin
                rb_nxt[j] = busy_vec[ra[j]];
            end
            if (ZERO_REG != 0 && ra[j] == '0) begin
                rd_nxt[j] = '0;
                rb_nxt[j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            rdata <= '0;
            rbusy <= '0;
        end else begin
            for (int j = 0; j < NR; j++) begin
                if (re[j]) begin
                    rdata[j*DATA_W +: DATA_W] <= rd_nxt[j];
                    rbusy[j]                  <= rb_nxt[j];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: default instance plus a ZERO_REG=1 / BYPASS=0 instance on shared stimulus.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        areset_n = 1'b0;
    logic [1:0]  we = '0;
    logic [5:0]  waddr = '0;
    logic [15:0] wdata = '0;
    logic [1:0]  re = '0;
    logic [5:0]  raddr = '0;
    logic        rsv_en = 1'b0;
    logic [2:0]  rsv_addr = '0;

    logic [15:0] rdata, a_rdata;
    logic [1:0]  rbusy, a_rbusy;
    logic [7:0]  busy_vec, a_busy_vec;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_mp u_dut (
        .clk(clk), .areset_n(areset_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec)
    );

    regfile_mp #(.ZERO_REG(1), .BYPASS(0)) u_alt (
        .clk(clk), .areset_n(areset_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(a_rdata), .rbusy(a_rbusy),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(a_busy_vec)
    );

    typedef struct {
        logic [1:0]  we;
        logic [5:0]  waddr;
        logic [15:0] wdata;
        logic [1:0]  re;
        logic [5:0]  raddr;
        logic        rsv_en;
        logic [2:0]  rsv_addr;
        logic [15:0] exp_rdata;
        logic [1:0]  exp_rbusy;
        logic [7:0]  exp_busy;
        logic [15:0] exp_a_rdata;
        logic [1:0]  exp_a_rbusy;
        logic [7:0]  exp_a_busy;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] w, input logic [5:0] wa, input logic [15:0] wd,
                         input logic [1:0] r, input logic [5:0] ra,
                         input logic rs, input logic [2:0] rsa);
        @(negedge clk);
        we = w; waddr = wa; wdata = wd; re = r; raddr = ra; rsv_en = rs; rsv_addr = rsa;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // {p1,p0} packing: waddr/raddr = {a1,a0}, wdata/rdata = {d1,d0}
        vt[0]  = '{2'b01, {3'd0,3'd3}, 16'h00A5, 2'b00, 6'd0, 1'b0, 3'd0,
                   16'h0000, 2'b00, 8'h00, 16'h0000, 2'b00, 8'h00};
        vt[1]  = '{2'b00, 6'd0, 16'h0000, 2'b01, {3'd0,3'd3}, 1'b0, 3'd0,
                   16'h00A5, 2'b00, 8'h00, 16'h00A5, 2'b00, 8'h00};
        vt[2]  = '{2'b01, {3'd0,3'd3}, 16'h0011, 2'b00, 6'd0, 1'b0, 3'd0,
                   16'h00A5, 2'b00, 8'h00, 16'h00A5, 2'b00, 8'h00};
        vt[3]  = '{2'b00, 6'd0, 16'h0000, 2'b10, {3'd3,3'd0}, 1'b0, 3'd0,
                   16'h11A5, 2'b00, 8'h00, 16'h11A5, 2'b00, 8'h00};
        vt[4]  = '{2'b11, {3'd5,3'd5}, 16'h3322, 2'b10, {3'd5,3'd0}, 1'b0, 3'd0,
                   16'h33A5, 2'b00, 8'h00, 16'h00A5, 2'b00, 8'h00};
        vt[5]  = '{2'b00, 6'd0, 16'h0000, 2'b01, {3'd0,3'd5}, 1'b0, 3'd0,
                   16'h3333, 2'b00, 8'h00, 16'h0033, 2'b00, 8'h00};
        vt[6]  = '{2'b00, 6'd0, 16'h0000, 2'b00, 6'd0, 1'b1, 3'd2,
                   16'h3333, 2'b00, 8'h04, 16'h0033, 2'b00, 8'h04};
        vt[7]  = '{2'b00, 6'd0, 16'h0000, 2'b01, {3'd0,3'd2}, 1'b0, 3'd0,
                   16'h3300, 2'b01, 8'h04, 16'h0000, 2'b01, 8'h04};
        vt[8]  = '{2'b10, {3'd2,3'd0}, 16'h7E00, 2'b00, 6'd0, 1'b0, 3'd0,
                   16'h3300, 2'b01, 8'h00, 16'h0000, 2'b01, 8'h00};
        vt[9]  = '{2'b01, {3'd0,3'd2}, 16'h005C, 2'b10, {3'd2,3'd0}, 1'b1, 3'd2,
                   16'h5C00, 2'b11, 8'h04, 16'h7E00, 2'b01, 8'h04};
        vt[10] = '{2'b00, 6'd0, 16'h0000, 2'b11, {3'd3,3'd2}, 1'b0, 3'd0,
                   16'h115C, 2'b01, 8'h04, 16'h115C, 2'b01, 8'h04};
        vt[11] = '{2'b01, {3'd0,3'd0}, 16'h00FF, 2'b01, {3'd0,3'd0}, 1'b1, 3'd6,
                   16'h11FF, 2'b00, 8'h44, 16'h1100, 2'b00, 8'h44};
        vt[12] = '{2'b00, 6'd0, 16'h0000, 2'b10, {3'd6,3'd0}, 1'b1, 3'd6,
                   16'h00FF, 2'b10, 8'h44, 16'h0000, 2'b10, 8'h44};

        #1;
        chk("reset_rdata", rdata, 16'h0000);
        chk("reset_rbusy", {14'd0, rbusy}, 16'h0000);
        chk("reset_busy_vec", {8'd0, busy_vec}, 16'h0000);
        #20;
        @(negedge clk);
        areset_n = 1'b1;

        for (int a = 0; a < 8; a++) begin
            drive(2'b00, 6'd0, 16'h0, 2'b11, {3'(7 - a), 3'(a)}, 1'b0, 3'd0);
            chk($sformatf("reset_read_%0d_rdata", a), rdata, 16'h0000);
            chk($sformatf("reset_read_%0d_rbusy", a), {14'd0, rbusy}, 16'h0000);
            chk($sformatf("reset_read_%0d_busy", a), {8'd0, busy_vec}, 16'h0000);
        end

        for (int i = 0; i < 13; i++) begin
            drive(vt[i].we, vt[i].waddr, vt[i].wdata, vt[i].re, vt[i].raddr,
                  vt[i].rsv_en, vt[i].rsv_addr);
            chk($sformatf("vec%0d_rdata", i), rdata, vt[i].exp_rdata);
            chk($sformatf("vec%0d_rbusy", i), {14'd0, rbusy}, {14'd0, vt[i].exp_rbusy});
            chk($sformatf("vec%0d_busy_vec", i), {8'd0, busy_vec}, {8'd0, vt[i].exp_busy});
            chk($sformatf("vec%0d_alt_rdata", i), a_rdata, vt[i].exp_a_rdata);
            chk($sformatf("vec%0d_alt_rbusy", i), {14'd0, a_rbusy}, {14'd0, vt[i].exp_a_rbusy});
            chk($sformatf("vec%0d_alt_busy_vec", i), {8'd0, a_busy_vec}, {8'd0, vt[i].exp_a_busy});
        end

        // Zero register: write r0 and reserve r0 in one cycle, read r0 on both ports.
        drive(2'b10, {3'd0,3'd0}, 16'hFF00, 2'b11, {3'd0,3'd0}, 1'b1, 3'd0);
        chk("zero_alt_rdata", a_rdata, 16'h0000);
        chk("zero_alt_rbusy", {14'd0, a_rbusy}, 16'h0000);
        chk("zero_alt_busy_vec", {8'd0, a_busy_vec}, 16'h0044);
        chk("zero_dflt_rdata", rdata, 16'hFFFF);
        chk("zero_dflt_rbusy", {14'd0, rbusy}, 16'h0003);
        chk("zero_dflt_busy_vec", {8'd0, busy_vec}, 16'h0045);

        // Mid-operation reset: r1=0x5A and busy, then reset between edges.
        drive(2'b01, {3'd0,3'd1}, 16'h005A, 2'b01, {3'd0,3'd1}, 1'b1, 3'd1);
        chk("pre_reset_rdata", rdata, 16'hFF5A);
        chk("pre_reset_busy_vec", {8'd0, busy_vec}, 16'h0047);
        drive(2'b00, 6'd0, 16'h0, 2'b00, 6'd0, 1'b0, 3'd0);
        #2;
        areset_n = 1'b0;
        #1;
        chk("async_reset_rdata", rdata, 16'h0000);
        chk("async_reset_rbusy", {14'd0, rbusy}, 16'h0000);
        chk("async_reset_busy_vec", {8'd0, busy_vec}, 16'h0000);
        chk("async_reset_alt_busy_vec", {8'd0, a_busy_vec}, 16'h0000);
        @(negedge clk);
        areset_n = 1'b1;
        drive(2'b00, 6'd0, 16'h0, 2'b01, {3'd0,3'd1}, 1'b0, 3'd0);
        chk("post_reset_r1", rdata, 16'h0000);
        chk("post_reset_busy_vec", {8'd0, busy_vec}, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the mini-CPU datapath; next generation of the 8x8 two-read-port register file.
- Adds configurable width, depth and port counts.
- Read ports are registered with per-port enable and optional write-through bypass.
- Optional hardwired zero register.
- Per-register busy scoreboard for multi-cycle producers; the decode stage reads busy together with the data.

Parameters:
- DATA_W, 8: register width in bits.
- DEPTH, 8: number of registers; power of two, at least 2; ADDR_W = $clog2(DEPTH).
- NR, 2: number of read ports, 1..4.
- NW, 2: number of write ports, 1..2.
- ZERO_REG, 0: 1 means register 0 always reads 0, ignores writes and is never busy.
- BYPASS, 1: 1 means a read in the same cycle as a write to the same address returns the new data.

Ports:
- clk  in  1  rising-edge clock.
- areset_n  in  1  asynchronous reset, active low.
- we  in  NW  per-write-port enable.
- waddr  in  NW*ADDR_W  write addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- wdata  in  NW*DATA_W  write data, packed the same way.
- re  in  NR  per-read-port enable.
- raddr  in  NR*ADDR_W  read addresses.
- rdata  out  NR*DATA_W  registered read data.
- rbusy  out  NR  registered busy flag of the register read.
- rsv_en  in  1  mark register rsv_addr busy.
- rsv_addr  in  ADDR_W  register to reserve.
- busy_vec  out  DEPTH  live scoreboard, bit i = register i busy.

Behaviour:
- Reset: while areset_n is low, asynchronously clear every register, rdata, rbusy and busy_vec to 0. Release is synchronous to clk. If reset asserts mid-operation, all pending writes and reservations in that cycle are lost.
- Write: on the rising edge, for each k with we[k]=1, mem[waddr[k]] <= wdata[k].
  - If two write ports target the same address in the same cycle, the higher index wins: port 1 over port 0.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Read latency: 1 cycle. If re[j]=1 at edge N, rdata[j] and rbusy[j] reflect raddr[j] after edge N.
  - If re[j]=0, rdata[j] and rbusy[j] hold their previous value.
- Bypass, BYPASS=1: if raddr[j] equals an active waddr[k] in the same cycle, rdata[j] gets the winning wdata (same priority as the write).
  - rbusy[j] gets the post-edge busy state of that register.
- Bypass, BYPASS=0: rdata[j] gets the pre-write array contents and rbusy[j] gets the pre-edge busy bit.
- Zero register: with ZERO_REG=1, a read of address 0 returns rdata=0 and rbusy=0 regardless of writes.
- Scoreboard, per register i, next-state priority:
  1. rsv_en=1 and rsv_addr=i: set busy (a new producer overrides a completing old one).
  2. Otherwise any active write to i: clear busy.
  3. Otherwise hold.
- Scoreboard corner cases:
  - A reservation of address 0 with ZERO_REG=1 is ignored.
  - Reserving an already-busy register keeps it busy.
  - A write to a non-busy register leaves it non-busy.
- busy_vec is the scoreboard flop output; it has no combinational path from the inputs.
- Address width: addresses are exactly ADDR_W bits, so no out-of-range case exists.
- No combinational input-to-output paths anywhere; all outputs are flops.

Decomposition:
- Shared package rf_pkg:
  - Default constants RF_DATA_W=8, RF_DEPTH=8.
  - Function rf_addr_w(depth) returning the $clog2 value.
  - Typedefs rf_addr_t and rf_data_t for default widths, used by decode and the ALU.
- Sub-module rf_scoreboard: busy bits plus the set/clear priority, NW clear ports and one set port, outputs busy_vec.
- regfile_mp instantiates rf_scoreboard once and keeps storage, write arbitration, bypass and read registers inline.

Test Plan (defaults unless stated):
- Reset values: hold areset_n=0 then release; read all 8 addresses on ports 0 and 1 -> rdata=0x00, rbusy=0, busy_vec=8'h00.
- Write then read: write 0xA5 to r3 on port 0, next cycle re[0]=1 with raddr=3 -> after one edge rdata[0]=0xA5. With re[0]=0 afterwards, rdata[0] stays 0xA5 while r3 is rewritten to 0x11.
- Write collision and bypass: in the same cycle port 0 writes r5=0x22, port 1 writes r5=0x33, read port 1 reads r5 -> rdata[1]=0x33 after that edge. With BYPASS=0, the same stimulus gives the old value 0x00 and the array holds 0x33.
- Scoreboard: rsv_en with r2 -> busy_vec=8'h04 after the edge and a read of r2 gives rbusy=1. A write to r2 of 0x7E clears it -> busy_vec=8'h00. Reserve and write r2 in the same cycle -> busy_vec=8'h04 and r2 = written data.
- ZERO_REG=1: write r0=0xFF and rsv_en r0 -> rdata=0x00, rbusy=0, busy_vec[0]=0.
- Mid-operation reset: pull areset_n low between edges while r1=0x5A and busy -> all outputs go to 0 immediately, before the next clk edge, and a subsequent read of r1 returns 0x00.
- Parameter sweep: DATA_W=16, DEPTH=16, NR=3, NW=1, random writes checked against a model -> no mismatch over 10k cycles.
